pe_stream_feeder: RTL

//  Sequencer that drives one MAC processing element (x/w/b/in_valid stream) and collects its d_o/o_valid results.

---
 rtl/pe_stream_feeder_pkg.sv | 25 ++
 rtl/pe_stream_feeder_if.sv | 35 +++
 rtl/pe_stream_feeder_vec_buf.sv | 27 ++
 rtl/pe_stream_feeder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pe_stream_feeder_pkg.sv
// Shared types, default sizes and width helpers for the PE stream feeder slice.
package pe_feed_pkg;

  localparam int INPUT_SIZE_DEF  = 226;
  localparam int NUM_NEURONS_DEF = 16;
  localparam int D_WL_DEF        = 16;
  localparam int FL_DEF          = 12;

  // Address width that never collapses to zero for tiny sizes.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  localparam int B_AW_DEF = clog2_min1(NUM_NEURONS_DEF);
  localparam int W_AW_DEF = clog2_min1(NUM_NEURONS_DEF * INPUT_SIZE_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_RUN,
    S_DRAIN,
    S_DONE
  } feed_state_t;

endpackage

// File: rtl/pe_stream_feeder_if.sv
// Weight/bias memory read ports plus the PE x/w/b stream and its result return path.
interface pe_stream_feeder_if
  import pe_feed_pkg::*;
#(
  parameter int D_WL = D_WL_DEF,
  parameter int WAW  = W_AW_DEF,
  parameter int NW   = B_AW_DEF
) ();

  logic            w_rd_en;
  logic [WAW-1:0]  w_rd_addr;
  logic [D_WL-1:0] w_rd_data;
  logic            b_rd_en;
  logic [NW-1:0]   b_rd_addr;
  logic [D_WL-1:0] b_rd_data;
  logic [D_WL-1:0] pe_x;
  logic [D_WL-1:0] pe_w;
  logic [D_WL-1:0] pe_b;
  logic            pe_in_valid;
  logic [D_WL-1:0] pe_d_o;
  logic            pe_o_valid;

  modport master (
    output w_rd_en, w_rd_addr, b_rd_en, b_rd_addr,
    output pe_x, pe_w, pe_b, pe_in_valid,
    input  w_rd_data, b_rd_data, pe_d_o, pe_o_valid
  );

  modport slave (
    input  w_rd_en, w_rd_addr, b_rd_en, b_rd_addr,
    input  pe_x, pe_w, pe_b, pe_in_valid,
    output w_rd_data, b_rd_data, pe_d_o, pe_o_valid
  );

endinterface

// File: rtl/pe_stream_feeder_vec_buf.sv
// Input-vector register file: one write port, one registered read port.
module pe_vec_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int D_WL  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [D_WL-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [D_WL-1:0] rd_data
);

  logic [D_WL-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pe_stream_feeder.sv
// Streams vector x weight beats plus per-neuron bias into one MAC PE and collects its results.
//   state   | meaning
//   S_IDLE  | waiting for start; vector writes accepted
//   S_BIAS  | read bias of neuron 0
//   S_RUN   | issue one beat per unpaused cycle
//   S_DRAIN | all beats issued, waiting for the last result
//   S_DONE  | one-cycle completion pulse
module pe_stream_feeder
  import pe_feed_pkg::*;
#(
  parameter int INPUT_SIZE  = INPUT_SIZE_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int D_WL        = D_WL_DEF,
  parameter int FL          = FL_DEF,
  localparam int VAW = clog2_min1(INPUT_SIZE),
  localparam int NW  = clog2_min1(NUM_NEURONS),
  localparam int WAW = clog2_min1(NUM_NEURONS * INPUT_SIZE),
  localparam int CW  = $clog2(NUM_NEURONS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vec_wr_en,
  input  logic [VAW-1:0]  vec_wr_addr,
  input  logic [D_WL-1:0] vec_wr_data,
  input  logic            start,
  input  logic            pause,
  output logic            busy,
  output logic            done,
  pe_stream_feeder_if.master bus,
  output logic            res_valid,
  output logic [NW-1:0]   res_idx,
  output logic [D_WL-1:0] res_data
);

  localparam logic [VAW-1:0] K_LAST  = VAW'(INPUT_SIZE - 1);
  localparam logic [NW-1:0]  N_LAST  = NW'(NUM_NEURONS - 1);
  localparam logic [CW-1:0]  RES_ALL = CW'(NUM_NEURONS);
  localparam logic [WAW-1:0] W_STEP  = WAW'(INPUT_SIZE);

  if (FL >= D_WL || INPUT_SIZE < 2 || INPUT_SIZE > 256) begin : g_bad_cfg
    $error("pe_stream_feeder: FL or INPUT_SIZE out of range");
  end

  feed_state_t     state, state_nx;
  logic [VAW-1:0]  k;
  logic [NW-1:0]   n;
  logic [WAW-1:0]  base;
  logic [CW-1:0]   res_cnt;
  logic            issue, b_en, valid_q, b_pend, in_run, accept, vec_we, addr_ok;
  logic [NW-1:0]   b_addr;
  logic [D_WL-1:0] vec_q, pe_b_q;

  if ((1 << VAW) == INPUT_SIZE) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign addr_ok = (vec_wr_addr < VAW'(INPUT_SIZE));
  end

  assign in_run = (state == S_BIAS) || (state == S_RUN) || (state == S_DRAIN);
  assign accept = (state == S_IDLE) && start;
  assign vec_we = vec_wr_en && (state == S_IDLE) && addr_ok;
  assign busy   = in_run;
  assign done   = (state == S_DONE);

  pe_vec_buf #(.DEPTH(INPUT_SIZE), .AW(VAW), .D_WL(D_WL)) u_vec_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vec_we),
    .wr_addr (vec_wr_addr),
    .wr_data (vec_wr_data),
    .rd_addr (k),
    .rd_data (vec_q)
  );

  // x and w both arrive one cycle after issue; gating keeps the stream zero between beats.
  assign bus.w_rd_en     = issue;
  assign bus.w_rd_addr   = issue ? (base + WAW'(k)) : '0;
  assign bus.b_rd_en     = b_en;
  assign bus.b_rd_addr   = b_addr;
  assign bus.pe_in_valid = valid_q;
  assign bus.pe_x        = valid_q ? vec_q : '0;
  assign bus.pe_w        = valid_q ? bus.w_rd_data : '0;
  assign bus.pe_b        = pe_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    b_en     = 1'b0;
    b_addr   = '0;
    case (state)
      S_IDLE:  if (start) state_nx = S_BIAS;
      S_BIAS: begin
        b_en     = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        if (!pause) begin
          issue = 1'b1;
          if (k == K_LAST) begin
            if (n == N_LAST) begin
              state_nx = S_DRAIN;
            end else begin
              b_en   = 1'b1;
              b_addr = n + NW'(1);
            end
          end
        end
      end
      S_DRAIN: if (res_cnt == RES_ALL) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      n         <= '0;
      base      <= '0;
      res_cnt   <= '0;
      valid_q   <= 1'b0;
      b_pend    <= 1'b0;
      pe_b_q    <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
    end else begin
      valid_q <= issue;
      b_pend  <= b_en;
      if (b_pend) pe_b_q <= bus.b_rd_data;

      if (accept) begin
        k    <= '0;
        n    <= '0;
        base <= '0;
      end else if (issue) begin
        if (k == K_LAST) begin
          k <= '0;
          if (n != N_LAST) begin
            n    <= n + NW'(1);
            base <= base + W_STEP;
          end
        end else begin
          k <= k + VAW'(1);
        end
      end

      // Results outside a run are forwarded but not counted.
      res_valid <= bus.pe_o_valid;
      if (bus.pe_o_valid) begin
        res_data <= bus.pe_d_o;
        res_idx  <= res_cnt[NW-1:0];
      end
      if (accept)                       res_cnt <= '0;
      else if (bus.pe_o_valid && in_run) res_cnt <= res_cnt + CW'(1);
    end
  end

endmodule
